// File: rtl/bit_deserializer_pkg.sv
// rtl/bit_deserializer_pkg.sv - shared types and sizing helpers for bit_deserializer (BIT_DESERIALIZER_PARITY_EN adds a parity bit per frame)
package bit_deserializer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic int FRAME_BITS(input int w);
`ifdef BIT_DESERIALIZER_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

    function automatic int CNT_W(input int w);
        return $clog2(FRAME_BITS(w));
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// rtl/deser_out_buf.sv - 2-entry output FIFO with head/tail registers and same-cycle push+pop
module deser_out_buf
    import bit_deserializer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         pop_ok;

    assign pop_ok = pop & (state_q != EMPTY);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop_ok})
                    2'b10: begin
                        tail_d  = push_data;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d = push_data;
                    default: ;
                endcase
            end
            FULL: begin
                // A push without a pop is discarded here; the top counts it.
                case ({push, pop_ok})
                    2'b01: begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                    2'b11: begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end
                    default: ;
                endcase
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign head  = head_q;
    assign valid = (state_q != EMPTY);
    assign full  = (state_q == FULL);

endmodule

// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - LSB-first serial-to-parallel stage with 2-entry output buffer and drop counter
// BIT_DESERIALIZER_PARITY_EN: frames carry a trailing even-parity bit that is checked before push.
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int W       = 8,
    parameter int DROP_CW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun,
    output logic               parity_err,
    output logic [DROP_CW-1:0] drop_count
);

    localparam int            FB   = FRAME_BITS(W);
    localparam int            CW   = CNT_W(W);
    localparam logic [CW-1:0] LAST = CW'(FB - 1);

    logic [W-1:0]       shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               overrun_q, overrun_d;
    logic               parity_err_q, parity_err_d;
    logic [DROP_CW-1:0] drop_q, drop_d;

    logic frame_done;
    logic par_fail;
    logic push;
    logic pop;
    logic buf_full;
    logic drop_ev;

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        frame_done = 1'b0;
        if (bit_valid) begin
            // Every data position is rewritten each frame, so no clear is needed between words.
            for (int i = 0; i < W; i++) begin
                if (cnt_q == CW'(i)) shift_d[i] = bit_in;
            end
            if (cnt_q == LAST) begin
                cnt_d      = '0;
                frame_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

`ifdef BIT_DESERIALIZER_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (bit_valid) par_d = frame_done ? 1'b0 : (par_q ^ bit_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end

    assign par_fail = frame_done & (par_q ^ bit_in);
`else
    assign par_fail = 1'b0;
`endif

    assign push    = frame_done & ~par_fail;
    assign pop     = out_valid & out_ready;
    assign drop_ev = push & buf_full & ~pop;

    always_comb begin
        overrun_d    = drop_ev;
        parity_err_d = par_fail;
        drop_d       = drop_q;
        if ((drop_ev | par_fail) && (drop_q != {DROP_CW{1'b1}})) drop_d = drop_q + DROP_CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
            drop_q       <= drop_d;
        end
    end

    deser_out_buf #(.W(W)) u_out_buf (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (shift_d),
        .pop       (pop),
        .head      (out_data),
        .valid     (out_valid),
        .full      (buf_full)
    );

    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// tb/tb_bit_deserializer.sv - directed bench for bit_deserializer (W=8, 2-bit drop counter)
module tb_bit_deserializer;

    localparam int W   = 8;
    localparam int DCW = 2;
`ifdef BIT_DESERIALIZER_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic           clk;
    logic           reset;
    logic           bit_in;
    logic           bit_valid;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           overrun;
    logic           parity_err;
    logic [DCW-1:0] drop_count;

    bit_deserializer #(.W(W), .DROP_CW(DCW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .parity_err (parity_err),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [7:0] word;
        int         gap;
        bit         early;
    } vec_t;

    vec_t       tbl [7];
    int         checks = 0;
    int         passes = 0;
    int         exp_drop = 0;
    logic [7:0] got [$];
    logic [7:0] b2b [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back(out_data);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required to end before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap_max, input bit early,
                             input bit rdy_last, input bit bad_par);
        for (int i = 0; i < FB; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                step();
                bit_valid = 1'b0;
            end
            step();
            if (i == FB - 1) begin
                if (early) check("no_early_completion", out_valid, 0);
                if (rdy_last) out_ready = 1'b1;
            end
            bit_valid = 1'b1;
            if (i < W) bit_in = w[i];
            else       bit_in = (^w) ^ bad_par;
        end
    endtask

    task automatic finish_word();
        step();
        bit_valid = 1'b0;
    endtask

    function automatic int sat_inc(input int v);
        return (v == (1 << DCW) - 1) ? v : v + 1;
    endfunction

    initial begin
        tbl[0] = '{8'h9A, 0, 1'b0};
        tbl[1] = '{8'h9A, 5, 1'b1};
        tbl[2] = '{8'h00, 0, 1'b1};
        tbl[3] = '{8'hFF, 2, 1'b1};
        tbl[4] = '{8'h55, 3, 1'b1};
        tbl[5] = '{8'h01, 0, 1'b1};
        tbl[6] = '{8'h80, 4, 1'b1};
        b2b = '{8'h12, 8'hA7, 8'hFE, 8'h00, 8'h69};

        reset = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("reset_out_data", out_data, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_overrun", overrun, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_drop_count", drop_count, 0);
        reset = 1'b0;
        step();

        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            send_word(tbl[v].word, tbl[v].gap, tbl[v].early, 1'b0, 1'b0);
            finish_word();
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_data", v), out_data, tbl[v].word);
            check($sformatf("vec%0d_overrun", v), overrun, 0);
            step();
            check($sformatf("vec%0d_valid_drop", v), out_valid, 0);
        end

        out_ready = 1'b0;
        send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        check("ovr_first_head", out_data, 8'hA5);
        send_word(8'h3C, 1, 1'b0, 1'b0, 1'b0);
        finish_word();
        check("ovr_head_stable", out_data, 8'hA5);
        check("ovr_no_overrun_yet", overrun, 0);
        send_word(8'hFF, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        exp_drop = sat_inc(exp_drop);
        check("ovr_pulse", overrun, 1);
        check("ovr_drop_count", drop_count, exp_drop);
        step();
        check("ovr_pulse_end", overrun, 0);
        check("ovr_head_kept", out_data, 8'hA5);
        check("ovr_valid_kept", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("ovr_pop1_data", out_data, 8'h3C);
        check("ovr_pop1_valid", out_valid, 1);
        step();
        check("ovr_pop2_empty", out_valid, 0);
        out_ready = 1'b0;

        send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        send_word(8'h22, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        send_word(8'h33, 0, 1'b0, 1'b1, 1'b0);
        finish_word();
        check("fullpop_no_overrun", overrun, 0);
        check("fullpop_head", out_data, 8'h22);
        check("fullpop_drop_same", drop_count, exp_drop);
        step();
        check("fullpop_next_head", out_data, 8'h33);
        check("fullpop_next_valid", out_valid, 1);
        step();
        check("fullpop_drained", out_valid, 0);

        got.delete();
        for (int k = 0; k < 5; k++) send_word(b2b[k], 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        repeat (3) step();
        check("b2b_count", got.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < got.size()) check($sformatf("b2b_word%0d", k), got[k], b2b[k]);
        end

`ifdef BIT_DESERIALIZER_PARITY_EN
        out_ready = 1'b1;
        send_word(8'h07, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        check("par_good_valid", out_valid, 1);
        check("par_good_data", out_data, 8'h07);
        check("par_good_no_err", parity_err, 0);
        step();
        send_word(8'h07, 0, 1'b0, 1'b0, 1'b1);
        finish_word();
        exp_drop = sat_inc(exp_drop);
        check("par_bad_err", parity_err, 1);
        check("par_bad_no_overrun", overrun, 0);
        check("par_bad_not_pushed", out_valid, 0);
        check("par_bad_drop", drop_count, exp_drop);
        step();
        check("par_bad_err_end", parity_err, 0);
        out_ready = 1'b0;
        send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        send_word(8'h22, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        send_word(8'h07, 0, 1'b0, 1'b0, 1'b1);
        finish_word();
        exp_drop = sat_inc(exp_drop);
        check("par_full_err", parity_err, 1);
        check("par_full_no_overrun", overrun, 0);
        check("par_full_drop", drop_count, exp_drop);
        out_ready = 1'b1;
        repeat (3) step();
        check("par_full_drained", out_valid, 0);
`endif

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bit_valid = 1'b1;
            bit_in = 1'b1;
        end
        step();
        bit_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_drop", drop_count, 0);
        check("midrst_data", out_data, 0);
        exp_drop = 0;
        step();
        reset = 1'b0;
        send_word(8'h0F, 0, 1'b1, 1'b0, 1'b0);
        finish_word();
        check("midrst_word_valid", out_valid, 1);
        check("midrst_word_data", out_data, 8'h0F);
        step();

        out_ready = 1'b0;
        send_word(8'hC1, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        send_word(8'hC2, 0, 1'b0, 1'b0, 1'b0);
        finish_word();
        for (int k = 0; k < 4; k++) begin
            send_word(8'h40 + 8'(k), 0, 1'b0, 1'b0, 1'b0);
            finish_word();
            exp_drop = sat_inc(exp_drop);
            check($sformatf("sat_overrun%0d", k), overrun, 1);
            check($sformatf("sat_drop%0d", k), drop_count, exp_drop);
        end
        out_ready = 1'b1;
        step();
        check("sat_drain_head", out_data, 8'hC2);
        step();
        check("sat_drain_empty", out_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
